// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: qualifies a host start pulse, then answers with
// the 80/80 us response and a 40-bit reading (4 bytes + checksum).
// Ports: clk, rst (sync, active high), dht_in (line level),
//   dht_oe (1 = pull line low), humidity_int/float,
//   temperature_int/float (reading bytes), busy, frame_done (pulse).
// Option: define DHT_ERR_INJECT_EN to add err_inject, which flips
//   checksum bit 0 when the reading is snapshotted.
module dht11_responder #(
  parameter int CLKS_PER_US   = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_float,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_float,
`ifdef DHT_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  output logic       busy,
  output logic       frame_done
);

  localparam int START_C = START_MIN_US * CLKS_PER_US;
  localparam int DELAY_C = RESP_DELAY_US * CLKS_PER_US;
  localparam int RESP_C  = 80 * CLKS_PER_US;
  localparam int LOW_C   = 50 * CLKS_PER_US;
  localparam int B0_C    = BIT0_HIGH_US * CLKS_PER_US;
  localparam int B1_C    = BIT1_HIGH_US * CLKS_PER_US;

  localparam int M1 = (START_C > DELAY_C) ? START_C : DELAY_C;
  localparam int M2 = (RESP_C > LOW_C) ? RESP_C : LOW_C;
  localparam int M3 = (B0_C > B1_C) ? B0_C : B1_C;
  localparam int M4 = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M4 > M3) ? M4 : M3;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] START_END = CW'(START_C - 1);
  localparam logic [CW-1:0] DELAY_END = CW'(DELAY_C - 1);
  localparam logic [CW-1:0] RESP_END  = CW'(RESP_C - 1);
  localparam logic [CW-1:0] LOW_END   = CW'(LOW_C - 1);
  localparam logic [CW-1:0] B0_END    = CW'(B0_C - 1);
  localparam logic [CW-1:0] B1_END    = CW'(B1_C - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_REL,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_idx;
  logic [39:0]   shreg;
  logic          sync1;
  logic          sync2;
  logic          line;
  logic [7:0]    sum;
  logic [7:0]    chk;
  logic [CW-1:0] hi_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= dht_in;
      sync2 <= sync1;
    end
  end

  assign line = sync2;

  assign sum = humidity_int + humidity_float
             + temperature_int + temperature_float;

`ifdef DHT_ERR_INJECT_EN
  assign chk = sum ^ {7'd0, err_inject};
`else
  assign chk = sum;
`endif

  // High width of the bit currently at the head of the shift register.
  assign hi_end = shreg[39] ? B1_END : B0_END;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!line) begin
            cnt   <= '0;
            state <= START_LOW;
          end
        end
        START_LOW: begin
          if (line) begin
            state <= IDLE;
          end else if (cnt == START_END) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= WAIT_REL;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        WAIT_REL: begin
          if (line) begin
            cnt   <= '0;
            state <= RESP_DELAY;
          end else if (cnt != '1) begin
            cnt <= cnt + ONE;
          end
        end
        RESP_DELAY: begin
          if (cnt == DELAY_END) begin
            cnt   <= '0;
            shreg <= {humidity_int, humidity_float,
                      temperature_int, temperature_float, chk};
            dht_oe <= 1'b1;
            state <= RESP_LOW;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RESP_LOW: begin
          if (cnt == RESP_END) begin
            cnt    <= '0;
            dht_oe <= 1'b0;
            state  <= RESP_HIGH;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RESP_HIGH: begin
          if (cnt == RESP_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            dht_oe  <= 1'b1;
            state   <= BIT_LOW;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        BIT_LOW: begin
          if (cnt == LOW_END) begin
            cnt    <= '0;
            dht_oe <= 1'b0;
            state  <= BIT_HIGH;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        BIT_HIGH: begin
          if (cnt == hi_end) begin
            cnt    <= '0;
            shreg  <= {shreg[38:0], 1'b0};
            dht_oe <= 1'b1;
            if (bit_idx == 6'd39) begin
              state <= END_LOW;
            end else begin
              bit_idx <= bit_idx + 6'd1;
              state   <= BIT_LOW;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        END_LOW: begin
          if (cnt == LOW_END) begin
            cnt        <= '0;
            dht_oe     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          dht_oe <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model drives start pulses, a line
// monitor decodes the response and checks it against queued frames.
module tb_dht11_responder;

  localparam int C = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_pull = 1'b0;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] hi_b = 8'h00;
  logic [7:0] hf_b = 8'h00;
  logic [7:0] ti_b = 8'h00;
  logic [7:0] tf_b = 8'h00;
  logic       err_inject = 1'b0;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;

  logic [39:0] q[$];

  // Open-drain wire: low if either side pulls.
  assign dht_in = !(host_pull || dht_oe);

  always #5 clk = !clk;
  always @(posedge clk) cyc++;

  dht11_responder #(
    .CLKS_PER_US  (C),
    .START_MIN_US (100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dht_in            (dht_in),
    .dht_oe            (dht_oe),
    .humidity_int      (hi_b),
    .humidity_float    (hf_b),
    .temperature_int   (ti_b),
    .temperature_float (tf_b),
`ifdef DHT_ERR_INJECT_EN
    .err_inject        (err_inject),
`endif
    .busy              (busy),
    .frame_done        (frame_done)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Line monitor: run lengths of dht_oe levels within a frame.
  int  lows[64];
  int  highs[64];
  int  nl = 0;
  int  nh = 0;
  int  run = 0;
  bit  in_frame = 0;
  logic prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      nl = 0;
      nh = 0;
      run = 0;
      prev = 1'b0;
    end else begin
      if (dht_oe != prev) begin
        if (in_frame) begin
          if (prev) begin
            if (nl < 64) lows[nl] = run;
            nl++;
          end else begin
            if (nh < 64) highs[nh] = run;
            nh++;
          end
        end else if (dht_oe) begin
          in_frame = 1;
          nl = 0;
          nh = 0;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = dht_oe;
      if (frame_done) begin
        logic [39:0] got;
        logic [39:0] exp;
        bit bad_low;
        bit bad_high;
        fd_cnt++;
        got = '0;
        bad_low = 0;
        bad_high = 0;
        chk("run_count", {nl, nh}, {32'd42, 32'd41});
        if (nl == 42 && nh == 41) begin
          chk("resp_low", lows[0], 80 * C);
          chk("resp_high", highs[0], 80 * C);
          chk("end_low", lows[41], 50 * C);
          for (int i = 1; i <= 40; i++) begin
            if (lows[i] != 50 * C) bad_low = 1;
            if (highs[i] == 70 * C) got = {got[38:0], 1'b1};
            else if (highs[i] == 26 * C) got = {got[38:0], 1'b0};
            else bad_high = 1;
          end
          chk("bit_low_width", bad_low, 0);
          chk("bit_high_width", bad_high, 0);
        end
        chk("queue_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp = q.pop_front();
          chk("frame_data", got, exp);
        end
        in_frame = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_oe(input logic lvl, input int lim, output bit ok);
    ok = 0;
    if (dht_oe === lvl) ok = 1;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (dht_oe === lvl) ok = 1;
    end
  endtask

  typedef struct {
    logic [7:0] hi;
    logic [7:0] hf;
    logic [7:0] ti;
    logic [7:0] tf;
    logic       inj;
    logic [7:0] csum;
    bit         chg;
    bit         pulse;
  } vec_t;

  task automatic run_frame(input vec_t v);
    bit ok;
    int t0;
    int n;
    int fd0;
    logic [39:0] exp;
    hi_b = v.hi;
    hf_b = v.hf;
    ti_b = v.ti;
    tf_b = v.tf;
    err_inject = v.inj;
    exp = {v.hi, v.hf, v.ti, v.tf, v.csum};
    q.push_back(exp);
    n = 3 + 30 * C + 160 * C + 50 * C;
    for (int i = 39; i >= 0; i--)
      n += 50 * C + (exp[i] ? 70 * C : 26 * C);
    fd0 = fd_cnt;
    host_pull = 1'b1;
    wait_cycles(150 * C);
    chk("busy_qualified", busy, 1);
    host_pull = 1'b0;
    t0 = cyc;
    if (v.chg) begin
      wait_oe(1'b1, 2000, ok);
      chk("tmo_resp_low", ok, 1);
      wait_cycles(10 * C);
      hi_b = 8'hFF;
      hf_b = 8'hFF;
      ti_b = 8'hFF;
      tf_b = 8'hFF;
    end
    if (v.pulse) begin
      wait_oe(1'b1, 2000, ok);
      wait_oe(1'b0, 2000, ok);
      chk("tmo_resp_high", ok, 1);
      wait_cycles(20 * C);
      host_pull = 1'b1;
      wait_cycles(20 * C);
      host_pull = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1;
    end
    chk("tmo_frame_done", ok, 1);
    chk("frame_latency", cyc - t0, n);
    wait_cycles(200);
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("busy_cleared", busy, 0);
    chk("line_released", dht_oe, 0);
  endtask

`ifdef DHT_ERR_INJECT_EN
  localparam int NV = 3;
`else
  localparam int NV = 2;
`endif

  initial begin
    vec_t vt[NV];
    bit ok;
    bit saw_busy;
    bit saw_oe;
    int fd0;

    vt[0] = '{8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 8'h55, 1'b1, 1'b1};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFC, 1'b0, 1'b0};
`ifdef DHT_ERR_INJECT_EN
    vt[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFD, 1'b0, 1'b0};
`endif

    wait_cycles(5);
    chk("reset_oe", dht_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    wait_cycles(10);

    // Short start: no response at all.
    fd0 = fd_cnt;
    saw_busy = 0;
    saw_oe = 0;
    host_pull = 1'b1;
    for (int i = 0; i < 60 * C; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    host_pull = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
      if (dht_oe) saw_oe = 1;
    end
    chk("short_start_busy", saw_busy, 0);
    chk("short_start_oe", saw_oe, 0);
    chk("short_start_done", fd_cnt - fd0, 0);

    // Reset during bit 12 low phase.
    fd0 = fd_cnt;
    hi_b = 8'h00;
    hf_b = 8'h00;
    ti_b = 8'h00;
    tf_b = 8'h00;
    host_pull = 1'b1;
    wait_cycles(150 * C);
    host_pull = 1'b0;
    ok = 1;
    for (int r = 0; r < 14; r++) begin
      bit o1;
      bit o2;
      wait_oe(1'b0, 2000, o1);
      wait_oe(1'b1, 2000, o2);
      if (!(o1 && o2)) ok = 0;
    end
    chk("tmo_bit12_low", ok, 1);
    wait_cycles(10 * C);
    chk("bit12_driving", dht_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_oe", dht_oe, 0);
    chk("rst_busy", busy, 0);
    wait_cycles(3);
    rst = 1'b0;
    saw_oe = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dht_oe) saw_oe = 1;
    end
    chk("no_resume_oe", saw_oe, 0);
    chk("no_resume_done", fd_cnt - fd0, 0);

    for (int k = 0; k < NV; k++) run_frame(vt[k]);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
